xup_shift_deserializer: RTL and testbench

//  Receive end of the XUP serial shift link: collects a serial bit stream

---
 rtl/xup_shift_deserializer.sv | 120 ++++++++++++
 tb/tb_xup_shift_deserializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/xup_shift_deserializer.sv
// Receive end of the XUP serial shift link: packs a serial bit stream into SIZE-bit words.
// Latency: 1 clk from the SIZE-th accepted bit to out_valid; held word double-buffered against the collector.
// Backpressure: none on the serial input; a word completing against an unconsumed held word is dropped and flagged.
module xup_shift_deserializer #(
  parameter int SIZE  = 4,
  // Output delay of the original behavioural model; this RTL applies no delay.
  parameter int DELAY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_in,
  input  logic                  shift_valid,
  input  logic                  dir,
  input  logic                  clear,
  input  logic                  out_ready,
  output logic [SIZE-1:0]       parallel_out,
  output logic                  out_valid,
  output logic                  overflow,
  output logic [$clog2(SIZE):0] bit_count
);

  localparam int CNT_W = $clog2(SIZE) + 1;

  // Reject illegal configurations at elaboration time.
  if (!((SIZE >= 2) && (SIZE <= 32) && (DELAY >= 0))) begin : g_bad_params
    $error("xup_shift_deserializer: SIZE must be 2..32 and DELAY non-negative");
  end

  typedef enum logic {
    IDLE    = 1'b0,   // no bits of the current word collected yet
    COLLECT = 1'b1    // between 1 and SIZE-1 bits collected
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   collector_q, collector_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [SIZE-1:0]   word_q, word_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;

  logic              eff_dir;
  logic [SIZE-1:0]   shifted;
  logic              last_bit;

  // Direction is sampled live on the first bit of a word, then frozen in dir_q.
  assign eff_dir  = (state_q == IDLE) ? dir : dir_q;
  assign shifted  = eff_dir ? {collector_q[SIZE-2:0], shift_in}
                            : {shift_in, collector_q[SIZE-1:1]};
  assign last_bit = (cnt_q == CNT_W'(SIZE - 1));

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      collector_q <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      word_q      <= '0;
      vld_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      collector_q <= collector_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      word_q      <= word_d;
      vld_q       <= vld_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state: bit collection, word hand-off to the holding register, overrun flag.
  always_comb begin
    state_d     = state_q;
    collector_d = collector_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    word_d      = word_q;
    vld_d       = vld_q;
    ovf_d       = ovf_q;

    // Consumer handshake is independent of clear; a same-edge load re-asserts below.
    if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end

    if (clear) begin
      // Partial word and overflow are dropped; any bit this cycle is ignored.
      state_d     = IDLE;
      collector_d = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end else if (shift_valid) begin
      collector_d = shifted;
      if (state_q == IDLE) begin
        dir_d = dir;
      end
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!vld_q || out_ready) begin
          word_d = shifted;
          vld_d  = 1'b1;
        end else begin
          ovf_d  = 1'b1;
        end
      end else begin
        state_d = COLLECT;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  assign parallel_out = word_q;
  assign out_valid    = vld_q;
  assign overflow     = ovf_q;
  assign bit_count    = cnt_q;

endmodule

// File: tb/tb_xup_shift_deserializer.sv
// Directed bench for xup_shift_deserializer at SIZE=4.
// Outputs are sampled 1 time unit after each rising edge.
// Serial input is driven without backpressure; out_ready is set per step.
module tb_xup_shift_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       shift_in;
  logic       shift_valid;
  logic       dir;
  logic       clear;
  logic       out_ready;
  logic [3:0] parallel_out;
  logic       out_valid;
  logic       overflow;
  logic [2:0] bit_count;

  int checks   = 0;
  int failures = 0;

  xup_shift_deserializer #(.SIZE(4), .DELAY(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .shift_in     (shift_in),
    .shift_valid  (shift_valid),
    .dir          (dir),
    .clear        (clear),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overflow     (overflow),
    .bit_count    (bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    shift_valid = 1'b1;
    shift_in    = b;
    tick();
  endtask

  task automatic idle();
    shift_valid = 1'b0;
    shift_in    = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  logic [7:0] lfsr;
  logic [3:0] exp_word;
  logic       b;
  int         seen;

  initial begin
    reset = 1'b1; shift_in = 1'b0; shift_valid = 1'b0; dir = 1'b1;
    clear = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_pout", 32'(parallel_out), 32'h0);
    chk("rst_vld",  32'(out_valid),    32'h0);
    chk("rst_ovf",  32'(overflow),     32'h0);
    chk("rst_cnt",  32'(bit_count),    32'h0);
    reset = 1'b0;
    tick();

    // 1: hold a word, start another, then reset asynchronously mid-word.
    out_ready = 1'b0;
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    chk("t1_held", 32'(parallel_out), 32'hF);
    send_bit(1); send_bit(0);
    chk("t1_cnt2", 32'(bit_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_vld",  32'(out_valid),    32'h0);
    chk("t1_async_cnt",  32'(bit_count),    32'h0);
    chk("t1_async_pout", 32'(parallel_out), 32'h0);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    send_bit(0); send_bit(1); send_bit(1); send_bit(1);
    chk("t1_fresh_vld",  32'(out_valid),    32'h1);
    chk("t1_fresh_word", 32'(parallel_out), 32'h7);
    idle();

    // 2: MSB-first then LSB-first with the same bit sequence.
    dir = 1'b1;
    send_bit(1); send_bit(0); send_bit(1);
    chk("t2_no_early_vld", 32'(out_valid), 32'h0);
    send_bit(1);
    chk("t2_msb_vld",  32'(out_valid),    32'h1);
    chk("t2_msb_word", 32'(parallel_out), 32'hB);
    idle();
    chk("t2_consumed", 32'(out_valid),    32'h0);
    chk("t2_kept",     32'(parallel_out), 32'hB);
    dir = 1'b0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    chk("t2_lsb_word", 32'(parallel_out), 32'hD);
    idle();

    // 3: dir flipped after the first bit has no effect on this word.
    dir = 1'b1;
    send_bit(1);
    dir = 1'b0;
    send_bit(0); send_bit(0); send_bit(0);
    chk("t3_latched_dir", 32'(parallel_out), 32'h8);
    idle();

    // 4a: overrun with consumer stalled.
    pulse_reset();
    tick();
    dir = 1'b1; out_ready = 1'b0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    chk("t4_first_word", 32'(parallel_out), 32'hA);
    send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    chk("t4_ovr_pout", 32'(parallel_out), 32'hA);
    chk("t4_ovr_vld",  32'(out_valid),    32'h1);
    chk("t4_ovr_flag", 32'(overflow),     32'h1);
    idle();
    chk("t4_ovf_sticky", 32'(overflow), 32'h1);

    // 5: clear after 3 bits, with the held word consumed in the same cycle.
    send_bit(1); send_bit(1); send_bit(1);
    chk("t5_cnt3", 32'(bit_count), 32'd3);
    clear = 1'b1; out_ready = 1'b1; shift_valid = 1'b1; shift_in = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_cnt",  32'(bit_count),    32'h0);
    chk("t5_clr_ovf",  32'(overflow),     32'h0);
    chk("t5_clr_hs",   32'(out_valid),    32'h0);
    chk("t5_clr_pout", 32'(parallel_out), 32'hA);
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    chk("t5_word", 32'(parallel_out), 32'h6);
    chk("t5_vld",  32'(out_valid),    32'h1);
    idle();

    // 4b: consumer ready on the completion edge of the second word.
    pulse_reset();
    tick();
    out_ready = 1'b0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    send_bit(0); send_bit(1); send_bit(0);
    out_ready = 1'b1;
    send_bit(1);
    chk("t4b_pout", 32'(parallel_out), 32'h5);
    chk("t4b_vld",  32'(out_valid),    32'h1);
    chk("t4b_ovf",  32'(overflow),     32'h0);
    idle();
    chk("t4b_drain", 32'(out_valid), 32'h0);

    // 6: 40 back-to-back LFSR bits, consumer always ready.
    dir = 1'b1; out_ready = 1'b1;
    lfsr = 8'hA5; exp_word = 4'h0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      b        = lfsr[0];
      lfsr     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      exp_word = {exp_word[2:0], b};
      send_bit(b);
      if (out_valid) seen++;
      if (i % 4 == 3) begin
        chk("t6_vld",  32'(out_valid),    32'h1);
        chk("t6_word", 32'(parallel_out), 32'(exp_word));
      end
    end
    idle();
    chk("t6_words", 32'(seen),     32'd10);
    chk("t6_ovf",   32'(overflow), 32'h0);
    chk("t6_cnt",   32'(bit_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
